// File: rtl/ecc_mem_pkg.sv
// Shared types and helpers for the ECC data-memory controller and its scrub timer.
package ecc_mem_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    H_RD,
    S_RD,
    S_WB
  } state_e;

  // SCRUB_CNT_W = $clog2(SCRUB_INTERVAL+1), never narrower than one bit.
  function automatic int scrub_cnt_w(input int interval);
    return (interval > 0) ? $clog2(interval + 1) : 1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ecc_scrub_timer.sv
// Free-running scrub interval timer: raises due_o after SCRUB_INTERVAL-1 cycles and
// holds there until the controller issues the scrub read (clear_i).
module ecc_scrub_timer
  import ecc_mem_pkg::*;
#(
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic due_o
);

  localparam int SCRUB_CNT_W = scrub_cnt_w(SCRUB_INTERVAL);
  localparam bit ENABLED     = (SCRUB_INTERVAL > 0);
  localparam logic [SCRUB_CNT_W-1:0] LAST = SCRUB_CNT_W'(ENABLED ? SCRUB_INTERVAL - 1 : 0);

  logic [SCRUB_CNT_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (!ENABLED || clear_i) begin
      timer_d = '0;
    end else if (timer_q != LAST) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Decoded rather than registered so a one-cycle interval scrubs back to back.
  assign due_o = ENABLED && (timer_q == LAST);

endmodule

// File: rtl/ecc_dmem_ctrl.sv
// ECC data-memory controller: host read/write port, SECDED report path to the
// memory, and a background scrubber that rewrites correctable words.
module ecc_dmem_ctrl
  import ecc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 39,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_uncorrectable,
  output logic                  mem_clk_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic [DATA_WIDTH-1:0] dec_corrected,
  input  logic                  dec_error,
  input  logic                  dec_uncorrectable,
  output logic                  mem_error,
  output logic                  mem_uncorrectable_error,
  output logic [DATA_WIDTH-1:0] mem_flips,
  output logic                  mem_ignore,
  output logic [CNT_W-1:0]      corr_count,
  output logic [CNT_W-1:0]      uncorr_count
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] scrub_addr_q, scrub_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [CNT_W-1:0]      corr_q, corr_d, uncorr_q, uncorr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d, rsp_unc_q, rsp_unc_d;
  logic                  scrub_due, host_go, scrub_go;

  // rst gates the accept terms so no strobe can leak out while reset is held.
  assign req_ready = rst && (state_q == IDLE);
  assign host_go   = req_ready && req_valid;
  assign scrub_go  = req_ready && !req_valid && scrub_due;

  ecc_scrub_timer #(
    .SCRUB_INTERVAL(SCRUB_INTERVAL)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst),
    .clear_i(scrub_go),
    .due_o  (scrub_due)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d                 = state_q;
    scrub_addr_d            = scrub_addr_q;
    wb_data_d               = wb_data_q;
    corr_d                  = corr_q;
    uncorr_d                = uncorr_q;
    rsp_valid_d             = 1'b0;
    rsp_rdata_d             = '0;
    rsp_err_d               = 1'b0;
    rsp_unc_d               = 1'b0;
    mem_clk_en              = 1'b0;
    mem_write_en            = 1'b0;
    mem_addr                = '0;
    mem_write_data          = '0;
    mem_ignore              = 1'b1;
    mem_error               = 1'b0;
    mem_uncorrectable_error = 1'b0;
    mem_flips               = '0;

    if (state_q == H_RD || state_q == S_RD) begin
      mem_ignore              = 1'b0;
      mem_error               = dec_error;
      mem_uncorrectable_error = dec_uncorrectable;
      mem_flips               = mem_read_data ^ dec_corrected;
    end

    unique case (state_q)
      IDLE: begin
        if (host_go) begin
          mem_clk_en     = 1'b1;
          mem_write_en   = req_write;
          mem_addr       = req_addr;
          mem_write_data = req_wdata;
          if (req_write) rsp_valid_d = 1'b1;
          else           state_d     = H_RD;
        end else if (scrub_go) begin
          mem_clk_en = 1'b1;
          mem_addr   = scrub_addr_q;
          state_d    = S_RD;
        end
      end
      H_RD: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = dec_corrected;
        rsp_err_d   = dec_error;
        rsp_unc_d   = dec_uncorrectable;
        state_d     = IDLE;
      end
      S_RD: begin
        if (dec_error && !dec_uncorrectable) begin
          corr_d    = sat_inc(corr_q);
          wb_data_d = dec_corrected;
          state_d   = S_WB;
        end else begin
          if (dec_uncorrectable) uncorr_d = sat_inc(uncorr_q);
          scrub_addr_d = scrub_addr_q + 1'b1;
          state_d      = IDLE;
        end
      end
      S_WB: begin
        mem_clk_en     = 1'b1;
        mem_write_en   = 1'b1;
        mem_addr       = scrub_addr_q;
        mem_write_data = wb_data_q;
        scrub_addr_d   = scrub_addr_q + 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      scrub_addr_q <= '0;
      wb_data_q    <= '0;
      corr_q       <= '0;
      uncorr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_unc_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scrub_addr_q <= scrub_addr_d;
      wb_data_q    <= wb_data_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      rsp_unc_q    <= rsp_unc_d;
    end
  end

  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_error         = rsp_err_q;
  assign rsp_uncorrectable = rsp_unc_q;
  assign corr_count        = corr_q;
  assign uncorr_count      = uncorr_q;

endmodule

// File: tb/tb_ecc_dmem_ctrl.sv
// Bench for ecc_dmem_ctrl: three instances (scrub off, interval 8, interval 1), each
// backed by a behavioural memory and a fault-injecting stand-in decoder.
module tb_ecc_dmem_ctrl;
  import ecc_mem_pkg::*;

  localparam int AW = 13;
  localparam int DW = 39;
  localparam int N  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_s       [N];
  logic          req_valid   [N];
  logic          req_ready   [N];
  logic [AW-1:0] req_addr    [N];
  logic          req_write   [N];
  logic [DW-1:0] req_wdata   [N];
  logic          rsp_valid   [N];
  logic [DW-1:0] rsp_rdata   [N];
  logic          rsp_err     [N];
  logic          rsp_unc     [N];
  logic          m_en        [N];
  logic          m_we        [N];
  logic [AW-1:0] m_addr      [N];
  logic [DW-1:0] m_wdata     [N];
  logic [DW-1:0] m_rdata     [N];
  logic [DW-1:0] dec_corr    [N];
  logic          dec_err     [N];
  logic          dec_unc     [N];
  logic          r_err       [N];
  logic          r_unc       [N];
  logic [DW-1:0] r_flips     [N];
  logic          r_ign       [N];
  logic [15:0]   corr_cnt    [N];
  logic [15:0]   uncorr_cnt  [N];

  ecc_dmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCRUB_INTERVAL(0)) u_a (
    .clk(clk), .rst(rst_s[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_write(req_write[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_err[0]),
    .rsp_uncorrectable(rsp_unc[0]), .mem_clk_en(m_en[0]), .mem_write_en(m_we[0]),
    .mem_addr(m_addr[0]), .mem_write_data(m_wdata[0]), .mem_read_data(m_rdata[0]),
    .dec_corrected(dec_corr[0]), .dec_error(dec_err[0]), .dec_uncorrectable(dec_unc[0]),
    .mem_error(r_err[0]), .mem_uncorrectable_error(r_unc[0]), .mem_flips(r_flips[0]),
    .mem_ignore(r_ign[0]), .corr_count(corr_cnt[0]), .uncorr_count(uncorr_cnt[0]));

  ecc_dmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCRUB_INTERVAL(8)) u_b (
    .clk(clk), .rst(rst_s[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_write(req_write[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_err[1]),
    .rsp_uncorrectable(rsp_unc[1]), .mem_clk_en(m_en[1]), .mem_write_en(m_we[1]),
    .mem_addr(m_addr[1]), .mem_write_data(m_wdata[1]), .mem_read_data(m_rdata[1]),
    .dec_corrected(dec_corr[1]), .dec_error(dec_err[1]), .dec_uncorrectable(dec_unc[1]),
    .mem_error(r_err[1]), .mem_uncorrectable_error(r_unc[1]), .mem_flips(r_flips[1]),
    .mem_ignore(r_ign[1]), .corr_count(corr_cnt[1]), .uncorr_count(uncorr_cnt[1]));

  ecc_dmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCRUB_INTERVAL(1)) u_c (
    .clk(clk), .rst(rst_s[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .req_write(req_write[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_error(rsp_err[2]),
    .rsp_uncorrectable(rsp_unc[2]), .mem_clk_en(m_en[2]), .mem_write_en(m_we[2]),
    .mem_addr(m_addr[2]), .mem_write_data(m_wdata[2]), .mem_read_data(m_rdata[2]),
    .dec_corrected(dec_corr[2]), .dec_error(dec_err[2]), .dec_uncorrectable(dec_unc[2]),
    .mem_error(r_err[2]), .mem_uncorrectable_error(r_unc[2]), .mem_flips(r_flips[2]),
    .mem_ignore(r_ign[2]), .corr_count(corr_cnt[2]), .uncorr_count(uncorr_cnt[2]));

  // Memory holds true codewords; flip[] is the fault pattern applied on read.
  bit [DW-1:0] mem_arr [N][2**AW];
  bit [DW-1:0] flip    [N][2**AW];
  bit [DW-1:0] rd_q    [N];
  bit [DW-1:0] fl_q    [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (m_en[i]) begin
        if (m_we[i]) mem_arr[i][m_addr[i]] <= m_wdata[i];
        else begin
          rd_q[i] <= mem_arr[i][m_addr[i]];
          fl_q[i] <= flip[i][m_addr[i]];
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_dec
    assign m_rdata[g]  = rd_q[g] ^ fl_q[g];
    assign dec_corr[g] = rd_q[g];
    assign dec_err[g]  = (fl_q[g] != '0);
    assign dec_unc[g]  = ($countones(fl_q[g]) > 1);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] flp;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    bit            exp_unc;
  } vec_t;

  vec_t vecs [8];

  localparam logic [DW-1:0] D_SCRUB = 39'h55_AAAA_5555;

  bit            exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;
  int            n_strobe, hit_cyc, n_wr;
  bit            done;

  initial begin
    vecs[0] = '{1'b1, 13'd5,    39'h12_3456_789A, '0,            '0,               1'b0, 1'b0};
    vecs[1] = '{1'b0, 13'd5,    '0,               '0,            39'h12_3456_789A, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 13'd5,    '0,               39'h8,         39'h12_3456_789A, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 13'h1FFF, 39'h7F_FFFF_FFFF, '0,            '0,               1'b0, 1'b0};
    vecs[4] = '{1'b0, 13'h1FFF, '0,               39'h3,         39'h7F_FFFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 13'd0,    39'h40_0000_0001, '0,            '0,               1'b0, 1'b0};
    vecs[6] = '{1'b0, 13'd0,    '0,               39'h40_0000_0000, 39'h40_0000_0001, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 13'h0AB,  '0,               '0,            '0,               1'b0, 1'b0};

    for (int i = 0; i < N; i++) begin
      rst_s[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0;
    end
    // Reset with a pending request on u_a: nothing may reach the memory port.
    req_valid[0] = 1'b1; req_addr[0] = 13'd5;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", req_ready[0], 0);
    check("rst_clk_en", m_en[0], 0);
    check("rst_addr", m_addr[0], 0);
    check("rst_ignore", r_ign[0], 1);
    check("rst_rsp_valid", rsp_valid[0], 0);
    check("rst_corr", corr_cnt[1], 0);
    check("rst_uncorr", uncorr_cnt[1], 0);
    req_valid[0] = 1'b0;

    // Host transactions from the vector table.
    @(negedge clk);
    rst_s[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      flip[0][vecs[i].addr] = vecs[i].flp;
      req_valid[0] = 1'b1; req_write[0] = vecs[i].wr;
      req_addr[0] = vecs[i].addr; req_wdata[0] = vecs[i].wdata;
      #1;
      check($sformatf("v%0d_ready", i), req_ready[0], 1);
      check($sformatf("v%0d_clk_en", i), m_en[0], 1);
      check($sformatf("v%0d_we", i), m_we[0], vecs[i].wr);
      check($sformatf("v%0d_addr", i), m_addr[0], vecs[i].addr);
      check($sformatf("v%0d_wdata", i), m_wdata[0], vecs[i].wdata);
      @(negedge clk);
      req_valid[0] = 1'b0;
      #1;
      if (vecs[i].wr) begin
        check($sformatf("v%0d_wr_rsp", i), rsp_valid[0], 1);
        check($sformatf("v%0d_wr_rdata", i), rsp_rdata[0], 0);
        check($sformatf("v%0d_wr_err", i), {rsp_err[0], rsp_unc[0]}, 0);
        check($sformatf("v%0d_wr_ignore", i), r_ign[0], 1);
      end else begin
        check($sformatf("v%0d_hrd_rsp", i), rsp_valid[0], 0);
        check($sformatf("v%0d_hrd_ready", i), req_ready[0], 0);
        check($sformatf("v%0d_hrd_no_wb", i), m_en[0], 0);
        check($sformatf("v%0d_hrd_ignore", i), r_ign[0], 0);
        check($sformatf("v%0d_hrd_merr", i), r_err[0], vecs[i].exp_err);
        check($sformatf("v%0d_hrd_munc", i), r_unc[0], vecs[i].exp_unc);
        check($sformatf("v%0d_hrd_flips", i), r_flips[0], vecs[i].flp);
        @(negedge clk);
        #1;
        check($sformatf("v%0d_rd_rsp", i), rsp_valid[0], 1);
        check($sformatf("v%0d_rd_rdata", i), rsp_rdata[0], vecs[i].exp_rdata);
        check($sformatf("v%0d_rd_err", i), rsp_err[0], vecs[i].exp_err);
        check($sformatf("v%0d_rd_unc", i), rsp_unc[0], vecs[i].exp_unc);
        check($sformatf("v%0d_rd_ignore", i), r_ign[0], 1);
        check($sformatf("v%0d_rd_ready", i), req_ready[0], 1);
      end
    end

    // Back-to-back writes, then a read whose successor is accepted at T+2.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 13'd10; req_wdata[0] = 39'h11_1111_1111;
    #1 check("b2b_w0_en", m_en[0], 1);
    @(negedge clk);
    req_addr[0] = 13'd11; req_wdata[0] = 39'h22_2222_2222;
    #1;
    check("b2b_w1_en", m_en[0], 1);
    check("b2b_w1_addr", m_addr[0], 11);
    check("b2b_w0_rsp", rsp_valid[0], 1);
    @(negedge clk);
    req_write[0] = 1'b0; req_addr[0] = 13'd10;
    #1;
    check("b2b_w1_rsp", rsp_valid[0], 1);
    check("b2b_r0_en", m_en[0], 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 13'd11;
    #1;
    check("b2b_r0_rsp", rsp_valid[0], 1);
    check("b2b_r0_data", rsp_rdata[0], 39'h11_1111_1111);
    check("b2b_r1_accept", m_en[0] && req_ready[0], 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    #1 check("b2b_r1_data", rsp_rdata[0], 39'h22_2222_2222);

    // Reset in H_RD: response dropped, no strobe while held, immediate accept after.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 13'd5;
    #1 check("mid_rst_accept", m_en[0], 1);
    @(negedge clk);
    rst_s[0] = 1'b0;
    #1;
    check("mid_rst_ignore", r_ign[0], 1);
    check("mid_rst_ready", req_ready[0], 0);
    check("mid_rst_clk_en", m_en[0], 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("mid_rst_rsp%0d", k), rsp_valid[0], 0);
      check($sformatf("mid_rst_en%0d", k), m_en[0], 0);
    end
    @(negedge clk);
    rst_s[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 13'd20; req_wdata[0] = 39'h3;
    #1 check("post_rst_accept", req_ready[0] && m_en[0] && m_we[0], 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    check("post_rst_rsp", rsp_valid[0], 1);

    // Scrub disabled: no strobes across 10000 idle cycles.
    n_strobe = 0;
    repeat (10000) begin
      @(negedge clk);
      if (m_en[0]) n_strobe++;
    end
    check("disabled_strobes", n_strobe, 0);

    // Interval 8: writeback at addr 0, collision, then an uncorrectable word at addr 2.
    flip[1][0] = 39'h400;
    flip[1][2] = 39'h11;
    @(negedge clk);
    for (int c = 0; c <= 33; c++) begin
      if (c > 0) @(negedge clk);
      case (c)
        0: begin
          rst_s[1] = 1'b1; req_valid[1] = 1'b1; req_write[1] = 1'b1;
          req_addr[1] = 13'd0; req_wdata[1] = D_SCRUB;
        end
        1, 16: req_valid[1] = 1'b0;
        15: begin
          req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 13'h100; req_wdata[1] = 39'h1;
        end
        default: ;
      endcase
      #1;
      exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
      case (c)
        0:  begin exp_en = 1'b1; exp_we = 1'b1; exp_wd = D_SCRUB; end
        7:  exp_en = 1'b1;
        9:  begin exp_en = 1'b1; exp_we = 1'b1; exp_wd = D_SCRUB; end
        15: begin exp_en = 1'b1; exp_we = 1'b1; exp_addr = 13'h100; exp_wd = 39'h1; end
        16: begin exp_en = 1'b1; exp_addr = 13'd1; end
        24: begin exp_en = 1'b1; exp_addr = 13'd2; end
        32: begin exp_en = 1'b1; exp_addr = 13'd3; end
        default: ;
      endcase
      check($sformatf("scr_c%0d_en", c), m_en[1], exp_en);
      if (exp_en) begin
        check($sformatf("scr_c%0d_we", c), m_we[1], exp_we);
        check($sformatf("scr_c%0d_addr", c), m_addr[1], exp_addr);
        if (exp_we) check($sformatf("scr_c%0d_wdata", c), m_wdata[1], exp_wd);
      end
      case (c)
        1:  check("scr_wr_rsp", rsp_valid[1], 1);
        8: begin
          check("scr_srd_ready", req_ready[1], 0);
          check("scr_srd_ignore", r_ign[1], 0);
          check("scr_srd_err", {r_err[1], r_unc[1]}, 2'b10);
          check("scr_srd_flips", r_flips[1], 39'h400);
        end
        9: begin
          check("scr_swb_ready", req_ready[1], 0);
          check("scr_swb_corr", corr_cnt[1], 1);
        end
        10: check("scr_idle_ready", req_ready[1], 1);
        16: check("col_host_rsp", rsp_valid[1], 1);
        17: check("col_clean_err", {r_ign[1], r_err[1], r_unc[1]}, 0);
        25: check("unc_report", {r_ign[1], r_err[1], r_unc[1]}, 3'b011);
        26: begin
          check("unc_count", uncorr_cnt[1], 1);
          check("unc_corr_held", corr_cnt[1], 1);
        end
        default: ;
      endcase
    end

    // Interval 1: continuous clean scrubs walk the address space and wrap.
    @(negedge clk);
    rst_s[2] = 1'b1;
    hit_cyc = -1; n_wr = 0; done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (m_en[2] && m_we[2]) n_wr++;
      if (m_en[2] && hit_cyc >= 0) begin
        check("wrap_cycle", c, hit_cyc + 2);
        check("wrap_addr", m_addr[2], 0);
        check("wrap_is_read", m_we[2], 0);
        done = 1'b1;
      end else if (m_en[2] && m_addr[2] == 13'h1FFF) begin
        check("wrap_hit_cycle", c, 16382);
        hit_cyc = c;
      end
    end
    check("wrap_found", done, 1);
    check("wrap_no_writes", n_wr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
